// File: rtl/exec_stage_mul.sv
// Execute/write-back stage behind the 4-entry register file.
// Does ADD/SUB/AND in one cycle, or an unsigned shift-add multiply over WIDTH cycles.
module exec_stage_mul #(
    parameter int WIDTH   = 32,
    parameter int REGNO_W = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   ReadData1,
    input  logic [WIDTH-1:0]   ReadData2,
    input  logic [REGNO_W-1:0] DestReg,
    output logic               Busy,
    output logic               RegWrite,
    output logic [REGNO_W-1:0] WriteRegNo,
    output logic [WIDTH-1:0]   WriteData
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_WB
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REGNO_W-1:0] dest_q, dest_d;
    logic               reg_write_q, reg_write_d;
    logic [REGNO_W-1:0] write_reg_no_q, write_reg_no_d;
    logic [WIDTH-1:0]   write_data_q, write_data_d;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   acc_step;

    always_comb begin
        alu_result = '0;
        case (Op)
            2'b00:   alu_result = ReadData1 + ReadData2;
            2'b01:   alu_result = ReadData1 - ReadData2;
            2'b10:   alu_result = ReadData1 & ReadData2;
            default: alu_result = '0;
        endcase
    end

    assign acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    // Results are loaded into the write-port registers on the edge that enters WB,
    // so the strobe and data appear together and stay put afterwards.
    always_comb begin
        state_d        = state_q;
        mcand_d        = mcand_q;
        mplr_d         = mplr_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        dest_d         = dest_q;
        reg_write_d    = 1'b0;
        write_reg_no_d = write_reg_no_q;
        write_data_d   = write_data_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    dest_d = DestReg;
                    if (Op == 2'b11) begin
                        mcand_d = ReadData1;
                        mplr_d  = ReadData2;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        reg_write_d    = 1'b1;
                        write_reg_no_d = DestReg;
                        write_data_d   = alu_result;
                        state_d        = S_WB;
                    end
                end
            end
            S_MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    reg_write_d    = 1'b1;
                    write_reg_no_d = dest_q;
                    write_data_d   = acc_step;
                    state_d        = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            mcand_q        <= '0;
            mplr_q         <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            dest_q         <= '0;
            reg_write_q    <= 1'b0;
            write_reg_no_q <= '0;
            write_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            mcand_q        <= mcand_d;
            mplr_q         <= mplr_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            dest_q         <= dest_d;
            reg_write_q    <= reg_write_d;
            write_reg_no_q <= write_reg_no_d;
            write_data_q   <= write_data_d;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign RegWrite   = reg_write_q;
    assign WriteRegNo = write_reg_no_q;
    assign WriteData  = write_data_q;

endmodule

// File: tb/tb_exec_stage_mul.sv
// Directed self-checking bench for exec_stage_mul, with a small register file model
// wired to the write port for the end-to-end scenario.
module tb_exec_stage_mul;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [1:0]  DestReg;
    logic        Busy;
    logic        RegWrite;
    logic [1:0]  WriteRegNo;
    logic [31:0] WriteData;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [4];

    exec_stage_mul #(.WIDTH(32), .REGNO_W(2)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .DestReg    (DestReg),
        .Busy       (Busy),
        .RegWrite   (RegWrite),
        .WriteRegNo (WriteRegNo),
        .WriteData  (WriteData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (RegWrite) rf[WriteRegNo] <= WriteData;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issues one op and waits (bounded) for its write pulse, then one more edge so
    // the register file model has absorbed the write.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] dest, output bit timed_out);
        Op = op; ReadData1 = a; ReadData2 = b; DestReg = dest; Start = 1'b1;
        tick();
        Start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (RegWrite) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; ReadData1 = '0; ReadData2 = '0; DestReg = '0;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        checks++;
        if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %b want 0", RegWrite); end
        checks++;
        if (WriteRegNo !== 2'd0) begin errors++; $display("[TB] FAIL reset_regno got %0d want 0", WriteRegNo); end
        checks++;
        if (WriteData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 00000000", WriteData); end
    endtask

    task automatic test_add_wrap();
        Op = 2'b00; ReadData1 = 32'hFFFF_FFFF; ReadData2 = 32'h0000_0001; DestReg = 2'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL add_regwrite got %b want 1", RegWrite); end
        checks++;
        if (WriteRegNo !== 2'd2) begin errors++; $display("[TB] FAIL add_regno got %0d want 2", WriteRegNo); end
        checks++;
        if (WriteData !== 32'h0) begin errors++; $display("[TB] FAIL add_data got %h want 00000000", WriteData); end
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy_wb got %b want 1", Busy); end
        tick();
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_after got %b want 0", Busy); end
        checks++;
        if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL add_pulse_width got %b want 0", RegWrite); end
    endtask

    task automatic test_back_to_back();
        Op = 2'b01; ReadData1 = 32'd5; ReadData2 = 32'd7; DestReg = 2'd1; Start = 1'b1;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hFFFF_FFFE || WriteRegNo !== 2'd1) begin
            errors++;
            $display("[TB] FAIL sub_write got we=%b reg=%0d data=%h want we=1 reg=1 data=FFFFFFFE",
                     RegWrite, WriteRegNo, WriteData);
        end
        // Start stays high through WB with new operands; it must not be taken until IDLE.
        Op = 2'b10; ReadData1 = 32'hF0F0_F0F0; ReadData2 = 32'hFF00_FF00; DestReg = 2'd0;
        tick();
        checks++;
        if (RegWrite !== 1'b0 || Busy !== 1'b0 || WriteData !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL b2b_idle_gap got we=%b busy=%b data=%h want we=0 busy=0 data=FFFFFFFE",
                     RegWrite, Busy, WriteData);
        end
        tick();
        Start = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hF000_F000 || WriteRegNo !== 2'd0) begin
            errors++;
            $display("[TB] FAIL and_write got we=%b reg=%0d data=%h want we=1 reg=0 data=F000F000",
                     RegWrite, WriteRegNo, WriteData);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL and_done got we=%b busy=%b want we=0 busy=0", RegWrite, Busy);
        end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] dest,
                            input logic [31:0] expected, input bit poke_start, input string tag);
        int pulses = 0;
        int busy_cycles = 0;
        int pulse_cycle = -1;
        logic [31:0] got_data = '0;
        logic [1:0]  got_reg = '0;
        Op = 2'b11; ReadData1 = a; ReadData2 = b; DestReg = dest; Start = 1'b1;
        tick();
        Start = 1'b0;
        ReadData1 = 32'hDEAD_BEEF; ReadData2 = 32'h1357_9BDF;
        for (int c = 1; c <= 40; c++) begin
            if (Busy) busy_cycles++;
            if (RegWrite) begin
                pulses++;
                pulse_cycle = c;
                got_data = WriteData;
                got_reg = WriteRegNo;
            end
            if (poke_start && c >= 2 && c <= 20) begin
                Start = 1'b1; Op = 2'b00; DestReg = 2'd1;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        checks++;
        if (pulses != 1) begin errors++; $display("[TB] FAIL %s_pulses got %0d want 1", tag, pulses); end
        checks++;
        if (pulse_cycle != 33) begin errors++; $display("[TB] FAIL %s_latency got %0d want 33", tag, pulse_cycle); end
        checks++;
        if (busy_cycles != 33) begin errors++; $display("[TB] FAIL %s_busy_cycles got %0d want 33", tag, busy_cycles); end
        checks++;
        if (got_data !== expected) begin errors++; $display("[TB] FAIL %s_data got %h want %h", tag, got_data, expected); end
        checks++;
        if (got_reg !== dest) begin errors++; $display("[TB] FAIL %s_regno got %0d want %0d", tag, got_reg, dest); end
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        Op = 2'b11; ReadData1 = 32'd3; ReadData2 = 32'd5; DestReg = 2'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (RegWrite) pulses++;
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", Busy); end
        checks++;
        if (WriteData !== 32'h0 || WriteRegNo !== 2'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs got reg=%0d data=%h want reg=0 data=00000000", WriteRegNo, WriteData);
        end
        for (int c = 0; c < 40; c++) begin
            if (RegWrite) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin errors++; $display("[TB] FAIL abort_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_reset_wins();
        Op = 2'b00; ReadData1 = 32'd1; ReadData2 = 32'd2; DestReg = 2'd1; Start = 1'b1; Reset = 1'b1;
        tick();
        Reset = 1'b0; Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wins got busy=%b we=%b want busy=0 we=0", Busy, RegWrite);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WriteData !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_wins_late got we=%b data=%h want we=0 data=00000000", RegWrite, WriteData);
        end
    endtask

    task automatic test_reg_file_loop();
        bit to;
        run_op(2'b00, 32'hA5A5_0000, 32'h0000_0001, 2'd0, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL rf_add_timeout got none want pulse"); end
        run_op(2'b11, 32'd7, 32'd9, 2'd1, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL rf_mul_timeout got none want pulse"); end
        checks++;
        if (rf[0] !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL rf_r0 got %h want A5A50001", rf[0]); end
        checks++;
        if (rf[1] !== 32'd63) begin errors++; $display("[TB] FAIL rf_r1 got %h want 0000003F", rf[1]); end
        run_op(2'b00, rf[0], rf[1], 2'd2, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL rf_sum_timeout got none want pulse"); end
        run_op(2'b01, rf[2], rf[0], 2'd3, to);
        checks++;
        if (rf[2] !== 32'hA5A5_0040) begin errors++; $display("[TB] FAIL rf_r2 got %h want A5A50040", rf[2]); end
        checks++;
        if (rf[3] !== 32'd63 || to) begin
            errors++;
            $display("[TB] FAIL rf_r3 got %h timeout=%b want 0000003F timeout=0", rf[3], to);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_mul(32'd12345, 32'd678, 2'd3, 32'h007F_B6F6, 1'b0, "mul_basic");
        test_mul(32'h0001_0000, 32'h0001_0000, 2'd2, 32'h0000_0000, 1'b1, "mul_wrap");
        test_reset_mid_mul();
        test_reset_wins();
        test_reg_file_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
